// File: rtl/fir_out_pkg.sv
// Shared definitions for the FIR output framer and its FIFO.
package fir_out_pkg;

  // Width of the FIR core's y_n output, shared with the core.
  localparam int unsigned FIR_DATA_W = 14;

  // Byte-serialiser FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2
  } state_t;

endpackage

// File: rtl/fir_out_framer_if.sv
// Sample-in / byte-out handshake bundle of the FIR output framer.
interface fir_out_framer_if
  import fir_out_pkg::*;
#(
  parameter int unsigned DATA_W = FIR_DATA_W
);

  logic [DATA_W-1:0] y_n;
  logic              y_valid;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;

  // Framer side: consumes samples, produces the byte stream.
  modport master (
    input  y_n,
    input  y_valid,
    input  byte_ready,
    output byte_out,
    output byte_valid,
    output byte_last
  );

  // Environment side: feeds samples, accepts bytes.
  modport slave (
    output y_n,
    output y_valid,
    output byte_ready,
    input  byte_out,
    input  byte_valid,
    input  byte_last
  );

endinterface

// File: rtl/fir_out_fifo.sv
// Small synchronous FIFO with combinational head read and registered level.
module fir_out_fifo
  import fir_out_pkg::*;
#(
  parameter int unsigned W     = FIR_DATA_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop;
  logic         do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer and occupancy update; push and pop together leave level unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage; a push into a full FIFO only happens alongside a pop of the same slot.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_out_framer.sv
// Buffers FIR samples and serialises them as one saturated byte or two raw bytes.
module fir_out_framer
  import fir_out_pkg::*;
#(
  parameter int unsigned DATA_W = FIR_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SHIFT  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_out_framer_if.master       bus,
  input  logic                   narrow,
  input  logic                   clr_ovf,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(127);
  localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-128);

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic              hmode;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              hs;
  logic              last_hs;
  logic              pop;
  logic              push;
  logic              drop;

  // Arithmetic shift then clamp to the signed byte range.
  function automatic logic [7:0] sat8(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = $signed(v) >>> SHIFT;
    if (s > SAT_MAX)      return 8'h7F;
    else if (s < SAT_MIN) return 8'h80;
    else                  return s[7:0];
  endfunction

  // Upper byte of the sample, sign-extended to 8 bits.
  function automatic logic [7:0] hi_byte(input logic [DATA_W-1:0] v);
    logic signed [15:0] ext;
    ext = 16'($signed(v));
    return ext[15:8];
  endfunction

  // Pop when idle or on the final byte's handshake so samples stream without bubbles.
  assign hs      = bus.byte_valid & bus.byte_ready;
  assign last_hs = hs & bus.byte_last;
  assign pop     = ~fifo_empty & ((state == ST_IDLE) | last_hs);
  assign push    = bus.y_valid & (~fifo_full | pop);
  assign drop    = bus.y_valid & fifo_full & ~pop;

  fir_out_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.y_n),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Byte serialiser FSM; output byte is precomputed when the state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      hold           <= '0;
      hmode          <= 1'b0;
      bus.byte_out   <= 8'h00;
      bus.byte_valid <= 1'b0;
      bus.byte_last  <= 1'b0;
    end else if (pop) begin
      state          <= ST_BYTE0;
      hold           <= fifo_dout;
      hmode          <= narrow;
      bus.byte_valid <= 1'b1;
      if (narrow) begin
        bus.byte_out  <= sat8(fifo_dout);
        bus.byte_last <= 1'b1;
      end else begin
        bus.byte_out  <= fifo_dout[7:0];
        bus.byte_last <= 1'b0;
      end
    end else if (last_hs) begin
      state          <= ST_IDLE;
      bus.byte_valid <= 1'b0;
      bus.byte_last  <= 1'b0;
    end else if (hs && (state == ST_BYTE0) && !hmode) begin
      state         <= ST_BYTE1;
      bus.byte_out  <= hi_byte(hold);
      bus.byte_last <= 1'b1;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)        ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_fir_out_framer.sv
// Directed self-checking bench for fir_out_framer (DATA_W=14, DEPTH=4, SHIFT=4).
module tb_fir_out_framer;
  import fir_out_pkg::*;

  localparam int unsigned DW    = 14;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SHIFT = 4;
  localparam int unsigned LW    = 3;

  logic          clk;
  logic          reset;
  logic          narrow;
  logic          clr_ovf;
  logic          ovf;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_err = 0;

  fir_out_framer_if #(.DATA_W(DW)) bus();

  fir_out_framer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .SHIFT  (SHIFT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .narrow  (narrow),
    .clr_ovf (clr_ovf),
    .ovf     (ovf),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== 10'h000) begin
      n_err++;
      $display("FAIL reset_stream got v=%b l=%b b=%h expected 0/0/00", bus.byte_valid, bus.byte_last, bus.byte_out);
    end
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b expected 0", ovf); end
    n_cmp++;
    if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d expected 0", level); end
    reset = 1'b0;
  endtask

  task automatic test_wide_single();
    narrow = 1'b0;
    bus.byte_ready = 1'b1;
    bus.y_n = 14'h1A5C;
    bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
    n_cmp++;
    if ({level, bus.byte_valid} !== {3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL wide_c1 got level=%0d v=%b expected level=1 v=0", level, bus.byte_valid);
    end
    tick();
    n_cmp++;
    if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== {1'b1, 1'b0, 8'h5C}) begin
      n_err++;
      $display("FAIL wide_lo got v=%b l=%b b=%h expected 1/0/5c", bus.byte_valid, bus.byte_last, bus.byte_out);
    end
    tick();
    n_cmp++;
    if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== {1'b1, 1'b1, 8'h1A}) begin
      n_err++;
      $display("FAIL wide_hi got v=%b l=%b b=%h expected 1/1/1a", bus.byte_valid, bus.byte_last, bus.byte_out);
    end
    tick();
    n_cmp++;
    if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL wide_end got v=%b expected 0", bus.byte_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] smp [2];
    logic [9:0]    exp [4];
    smp = '{14'h2A5C, 14'h0123};
    exp = '{10'h25C, 10'h3EA, 10'h223, 10'h301};
    narrow = 1'b0;
    bus.byte_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.y_valid = (c < 2);
      if (c < 2) bus.y_n = smp[c];
      if (c >= 2 && c < 6) begin
        n_cmp++;
        if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== exp[c-2]) begin
          n_err++;
          $display("FAIL b2b_byte%0d got %h expected %h", c - 2, {bus.byte_valid, bus.byte_last, bus.byte_out}, exp[c-2]);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got v=%b expected 0", bus.byte_valid); end
      end
      tick();
    end
  endtask

  task automatic test_narrow();
    logic [DW-1:0] smp [5];
    logic [7:0]    exp [5];
    smp = '{14'h1FFF, 14'h2000, 14'h07F0, 14'h0050, 14'h3FF0};
    exp = '{8'h7F, 8'h80, 8'h7F, 8'h05, 8'hFF};
    narrow = 1'b1;
    bus.byte_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.y_valid = (c < 5);
      if (c < 5) bus.y_n = smp[c];
      if (c >= 2 && c < 7) begin
        n_cmp++;
        if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== {1'b1, 1'b1, exp[c-2]}) begin
          n_err++;
          $display("FAIL narrow_%0d got v=%b l=%b b=%h expected 1/1/%h", c - 2, bus.byte_valid, bus.byte_last, bus.byte_out, exp[c-2]);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL narrow_end got v=%b expected 0", bus.byte_valid); end
      end
      tick();
    end
    narrow = 1'b0;
  endtask

  task automatic test_backpressure();
    narrow = 1'b0;
    bus.byte_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.y_valid = (c == 0);
      bus.y_n = 14'h0ABC;
      if (c >= 2 && c <= 7) begin
        n_cmp++;
        if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== {1'b1, 1'b0, 8'hBC}) begin
          n_err++;
          $display("FAIL bp_hold%0d got v=%b l=%b b=%h expected 1/0/bc", c, bus.byte_valid, bus.byte_last, bus.byte_out);
        end
      end
      if (c == 7) bus.byte_ready = 1'b1;
      if (c == 8) begin
        n_cmp++;
        if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== {1'b1, 1'b1, 8'h0A}) begin
          n_err++;
          $display("FAIL bp_hi got v=%b l=%b b=%h expected 1/1/0a", bus.byte_valid, bus.byte_last, bus.byte_out);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL bp_end got v=%b expected 0", bus.byte_valid); end
      end
      tick();
    end
  endtask

  // One sample goes to the holding register, so it takes six pushes to overflow.
  task automatic test_overflow();
    int         idx;
    int         k;
    logic [8:0] exp;
    narrow = 1'b0;
    bus.byte_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.y_valid = 1'b1;
      bus.y_n = 14'((c + 1) * 'h110);
      if (c == 5) begin
        n_cmp++;
        if ({level, ovf} !== {3'd4, 1'b0}) begin
          n_err++;
          $display("FAIL ovf_prefull got level=%0d ovf=%b expected 4/0", level, ovf);
        end
      end
      tick();
    end
    bus.y_valid = 1'b0;
    n_cmp++;
    if ({level, ovf} !== {3'd4, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_set got level=%0d ovf=%b expected 4/1", level, ovf);
    end
    bus.byte_ready = 1'b1;
    idx = 0;
    for (int t = 0; t < 40 && idx < 10; t++) begin
      if (bus.byte_valid) begin
        k = idx / 2 + 1;
        exp = (idx % 2 == 1) ? {1'b1, 8'(k)} : {1'b0, 8'(k * 16)};
        n_cmp++;
        if ({bus.byte_last, bus.byte_out} !== exp) begin
          n_err++;
          $display("FAIL ovf_drain%0d got l=%b b=%h expected %h", idx, bus.byte_last, bus.byte_out, exp);
        end
        idx++;
      end
      tick();
    end
    n_cmp++;
    if (idx != 10) begin n_err++; $display("FAIL ovf_drain_count got %0d bytes expected 10", idx); end
    n_cmp++;
    if ({bus.byte_valid, level, ovf} !== {1'b0, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_after_drain got v=%b level=%0d ovf=%b expected 0/0/1", bus.byte_valid, level, ovf);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b expected 0", ovf); end
  endtask

  task automatic test_full_push_pop();
    int         idx;
    int         k;
    logic [8:0] exp;
    narrow = 1'b0;
    bus.byte_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.y_valid = 1'b1;
      bus.y_n = 14'((c + 1) * 'h110);
      tick();
    end
    bus.y_valid = 1'b0;
    n_cmp++;
    if ({level, bus.byte_valid, bus.byte_last, bus.byte_out} !== {3'd4, 1'b1, 1'b0, 8'h10}) begin
      n_err++;
      $display("FAIL fpp_full got level=%0d v=%b l=%b b=%h expected 4/1/0/10", level, bus.byte_valid, bus.byte_last, bus.byte_out);
    end
    bus.byte_ready = 1'b1;
    tick();
    n_cmp++;
    if ({level, bus.byte_last, bus.byte_out} !== {3'd4, 1'b1, 8'h01}) begin
      n_err++;
      $display("FAIL fpp_byte1 got level=%0d l=%b b=%h expected 4/1/01", level, bus.byte_last, bus.byte_out);
    end
    bus.y_valid = 1'b1;
    bus.y_n = 14'(6 * 'h110);
    tick();
    bus.y_valid = 1'b0;
    n_cmp++;
    if ({level, ovf} !== {3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL fpp_accept got level=%0d ovf=%b expected 4/0", level, ovf);
    end
    idx = 0;
    for (int t = 0; t < 40 && idx < 10; t++) begin
      if (bus.byte_valid) begin
        k = idx / 2 + 2;
        exp = (idx % 2 == 1) ? {1'b1, 8'(k)} : {1'b0, 8'(k * 16)};
        n_cmp++;
        if ({bus.byte_last, bus.byte_out} !== exp) begin
          n_err++;
          $display("FAIL fpp_drain%0d got l=%b b=%h expected %h", idx, bus.byte_last, bus.byte_out, exp);
        end
        idx++;
      end
      tick();
    end
    n_cmp++;
    if (idx != 10) begin n_err++; $display("FAIL fpp_drain_count got %0d bytes expected 10", idx); end
  endtask

  task automatic test_reset_mid();
    narrow = 1'b0;
    bus.byte_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.y_valid = 1'b1;
      bus.y_n = 14'((c + 1) * 'h110);
      tick();
    end
    bus.y_valid = 1'b0;
    bus.byte_ready = 1'b1;
    tick();
    n_cmp++;
    if ({level, bus.byte_valid, bus.byte_last, bus.byte_out} !== {3'd3, 1'b1, 1'b1, 8'h01}) begin
      n_err++;
      $display("FAIL rst_mid_pre got level=%0d v=%b l=%b b=%h expected 3/1/1/01", level, bus.byte_valid, bus.byte_last, bus.byte_out);
    end
    bus.byte_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bus.byte_valid, level, ovf} !== {1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid_post got v=%b level=%0d ovf=%b expected 0/0/0", bus.byte_valid, level, ovf);
    end
    bus.byte_ready = 1'b1;
    bus.y_valid = 1'b1;
    bus.y_n = 14'h3E81;
    tick();
    bus.y_valid = 1'b0;
    n_cmp++;
    if ({level, bus.byte_valid} !== {3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL rst_new_c1 got level=%0d v=%b expected 1/0", level, bus.byte_valid);
    end
    tick();
    n_cmp++;
    if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== {1'b1, 1'b0, 8'h81}) begin
      n_err++;
      $display("FAIL rst_new_lo got v=%b l=%b b=%h expected 1/0/81", bus.byte_valid, bus.byte_last, bus.byte_out);
    end
    tick();
    n_cmp++;
    if ({bus.byte_valid, bus.byte_last, bus.byte_out} !== {1'b1, 1'b1, 8'hFE}) begin
      n_err++;
      $display("FAIL rst_new_hi got v=%b l=%b b=%h expected 1/1/fe", bus.byte_valid, bus.byte_last, bus.byte_out);
    end
    tick();
    n_cmp++;
    if (bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL rst_new_end got v=%b expected 0", bus.byte_valid); end
  endtask

  initial begin
    reset = 1'b1;
    narrow = 1'b0;
    clr_ovf = 1'b0;
    bus.y_n = '0;
    bus.y_valid = 1'b0;
    bus.byte_ready = 1'b0;
    test_reset();
    test_wide_single();
    test_back_to_back();
    test_narrow();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

endmodule
